// File: rtl/store_align_unit_pkg.sv
// rtl/store_align_unit_pkg.sv - store type codes and FSM state encoding
package store_align_unit_pkg;

  localparam logic [1:0] ST_SB  = 2'b00;
  localparam logic [1:0] ST_SH  = 2'b01;
  localparam logic [1:0] ST_SW  = 2'b10;
  localparam logic [1:0] ST_BAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT1 = 2'b01,
    BEAT2 = 2'b10
  } state_e;

endpackage

// File: rtl/store_lane_gen.sv
// rtl/store_lane_gen.sv - byte-enable mask and lane-shifted data for one store
module store_lane_gen
  import store_align_unit_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [1:0]  type_i,
  input  logic [31:0] data_i,
  output logic [7:0]  mask_o,
  output logic [63:0] data_o,
  output logic        span_o
);

  logic [7:0] base;

  always_comb begin
    base = 8'h00;
    case (type_i)
      ST_SB:   base = 8'h01;
      ST_SH:   base = 8'h03;
      ST_SW:   base = 8'h0F;
      default: base = 8'h00;
    endcase
    mask_o = base << off_i;
    data_o = {32'b0, data_i} << {off_i, 3'b000};
    span_o = |mask_o[7:4];
  end

endmodule

// File: rtl/store_align_unit.sv
// rtl/store_align_unit.sv - splits byte-addressed stores into word writes with byte enables
module store_align_unit
  import store_align_unit_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqData,
  input  logic [1:0]  ReqType,
  output logic        MemValid,
  input  logic        MemReady,
  output logic [31:0] MemAddr,
  output logic [3:0]  MemWE,
  output logic [31:0] MemWD,
  output logic        Done
);

  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  we_q, we_d;
  logic [31:0] wd_q, wd_d;
  logic        done_q, done_d;
  logic [3:0]  hi_we_q, hi_we_d;
  logic [31:0] hi_wd_q, hi_wd_d;
  logic        span_q, span_d;

  logic [7:0]  lane_mask;
  logic [63:0] lane_data;
  logic        lane_span;
  logic        accept;

  store_lane_gen u_lane (
    .off_i  (ReqAddr[1:0]),
    .type_i (ReqType),
    .data_i (ReqData),
    .mask_o (lane_mask),
    .data_o (lane_data),
    .span_o (lane_span)
  );

  assign ReqReady = (state_q == IDLE) && RST_N;
  assign accept   = ReqValid && ReqReady;

  // Beat 1 is loaded straight from the lane generator at accept; the upper half is parked for beat 2.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wd_d    = wd_q;
    done_d  = 1'b0;
    hi_we_d = hi_we_q;
    hi_wd_d = hi_wd_q;
    span_d  = span_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (ReqType == ST_BAD) begin
            done_d = 1'b1;
          end else begin
            state_d = BEAT1;
            valid_d = 1'b1;
            addr_d  = {ReqAddr[31:2], 2'b00};
            we_d    = lane_mask[3:0];
            wd_d    = lane_data[31:0];
            hi_we_d = lane_mask[7:4];
            hi_wd_d = lane_data[63:32];
            span_d  = lane_span;
          end
        end
      end
      BEAT1: begin
        if (MemReady) begin
          if (span_q) begin
            state_d = BEAT2;
            addr_d  = addr_q + 32'd4;
            we_d    = hi_we_q;
            wd_d    = hi_wd_q;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            we_d    = 4'b0000;
            done_d  = 1'b1;
          end
        end
      end
      BEAT2: begin
        if (MemReady) begin
          state_d = IDLE;
          valid_d = 1'b0;
          we_d    = 4'b0000;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        we_d    = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      addr_q  <= 32'd0;
      we_q    <= 4'b0000;
      wd_q    <= 32'd0;
      done_q  <= 1'b0;
      hi_we_q <= 4'b0000;
      hi_wd_q <= 32'd0;
      span_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
      hi_we_q <= hi_we_d;
      hi_wd_q <= hi_wd_d;
      span_q  <= span_d;
    end
  end

  assign MemValid = valid_q;
  assign MemAddr  = addr_q;
  assign MemWE    = we_q;
  assign MemWD    = wd_q;
  assign Done     = done_q;

endmodule

// File: tb/tb_store_align_unit.sv
// tb/tb_store_align_unit.sv - directed vector bench for store_align_unit
module tb_store_align_unit;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        ReqValid;
  logic        ReqReady;
  logic [31:0] ReqAddr;
  logic [31:0] ReqData;
  logic [1:0]  ReqType;
  logic        MemValid;
  logic        MemReady;
  logic [31:0] MemAddr;
  logic [3:0]  MemWE;
  logic [31:0] MemWD;
  logic        Done;

  int n_cmp  = 0;
  int n_fail = 0;

  store_align_unit dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .ReqValid (ReqValid),
    .ReqReady (ReqReady),
    .ReqAddr  (ReqAddr),
    .ReqData  (ReqData),
    .ReqType  (ReqType),
    .MemValid (MemValid),
    .MemReady (MemReady),
    .MemAddr  (MemAddr),
    .MemWE    (MemWE),
    .MemWD    (MemWD),
    .Done     (Done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  typ;
    logic [31:0] addr;
    logic [31:0] data;
    logic        span;
    logic [31:0] a1;
    logic [3:0]  we1;
    logic [31:0] wd1;
    logic [31:0] a2;
    logic [3:0]  we2;
    logic [31:0] wd2;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] we);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{we[i]}};
    return m;
  endfunction

  task automatic chk_beat(input string name, input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
    chk({name, ".valid"}, {31'd0, MemValid}, 32'd1);
    chk({name, ".addr"}, MemAddr, a);
    chk({name, ".we"}, {28'd0, MemWE}, {28'd0, we});
    chk({name, ".wd"}, MemWD & lanes(we), wd & lanes(we));
  endtask

  task automatic issue(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    ReqValid = 1'b1;
    ReqType  = t;
    ReqAddr  = a;
    ReqData  = d;
    chk("req_ready_before_accept", {31'd0, ReqReady}, 32'd1);
    tick();
    ReqValid = 1'b0;
    ReqAddr  = 32'hDEAD_0000;
    ReqData  = 32'h5555_5555;
    ReqType  = 2'b00;
  endtask

  initial begin
    vecs[0] = '{2'b10, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0, 4'b0000, 32'h0};
    vecs[1] = '{2'b00, 32'h0000_0203, 32'h0000_00AB, 1'b0, 32'h0000_0200, 4'b1000, 32'hAB00_0000, 32'h0, 4'b0000, 32'h0};
    vecs[2] = '{2'b10, 32'h0000_0105, 32'h1122_3344, 1'b1, 32'h0000_0104, 4'b1110, 32'h2233_4400, 32'h0000_0108, 4'b0001, 32'h0000_0011};
    vecs[3] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_BEEF, 1'b1, 32'hFFFF_FFFC, 4'b1000, 32'hEF00_0000, 32'h0000_0000, 4'b0001, 32'h0000_00BE};
    vecs[4] = '{2'b01, 32'h0000_0302, 32'h0000_CAFE, 1'b0, 32'h0000_0300, 4'b1100, 32'hCAFE_0000, 32'h0, 4'b0000, 32'h0};
    vecs[5] = '{2'b00, 32'h0000_0001, 32'hFFFF_FF5A, 1'b0, 32'h0000_0000, 4'b0010, 32'h0000_5A00, 32'h0, 4'b0000, 32'h0};
    vecs[6] = '{2'b10, 32'h0000_000F, 32'hA1B2_C3D4, 1'b1, 32'h0000_000C, 4'b1000, 32'hD400_0000, 32'h0000_0010, 4'b0111, 32'h00A1_B2C3};
    vecs[7] = '{2'b01, 32'h0000_0011, 32'h0000_1234, 1'b0, 32'h0000_0010, 4'b0110, 32'h0012_3400, 32'h0, 4'b0000, 32'h0};

    RST_N    = 1'b0;
    ReqValid = 1'b0;
    ReqAddr  = 32'h0;
    ReqData  = 32'h0;
    ReqType  = 2'b00;
    MemReady = 1'b1;
    tick();
    tick();
    chk("rst.valid", {31'd0, MemValid}, 32'd0);
    chk("rst.we", {28'd0, MemWE}, 32'd0);
    chk("rst.addr", MemAddr, 32'd0);
    chk("rst.wd", MemWD, 32'd0);
    chk("rst.done", {31'd0, Done}, 32'd0);
    chk("rst.ready", {31'd0, ReqReady}, 32'd0);
    RST_N = 1'b1;
    #1;
    chk("rst.ready_after_release", {31'd0, ReqReady}, 32'd1);

    for (int v = 0; v < 8; v++) begin
      issue(vecs[v].typ, vecs[v].addr, vecs[v].data);
      chk_beat($sformatf("v%0d.b1", v), vecs[v].a1, vecs[v].we1, vecs[v].wd1);
      chk($sformatf("v%0d.b1_done", v), {31'd0, Done}, 32'd0);
      chk($sformatf("v%0d.b1_ready", v), {31'd0, ReqReady}, 32'd0);
      tick();
      if (vecs[v].span) begin
        chk_beat($sformatf("v%0d.b2", v), vecs[v].a2, vecs[v].we2, vecs[v].wd2);
        chk($sformatf("v%0d.b2_done", v), {31'd0, Done}, 32'd0);
        tick();
      end
      chk($sformatf("v%0d.end_valid", v), {31'd0, MemValid}, 32'd0);
      chk($sformatf("v%0d.end_we", v), {28'd0, MemWE}, 32'd0);
      chk($sformatf("v%0d.done", v), {31'd0, Done}, 32'd1);
      chk($sformatf("v%0d.done_ready", v), {31'd0, ReqReady}, 32'd1);
    end
    tick();
    chk("post_vec.done_clear", {31'd0, Done}, 32'd0);

    // Stall beat 1 while a competing request waits.
    MemReady = 1'b0;
    issue(2'b10, 32'h0000_0105, 32'h1122_3344);
    ReqValid = 1'b1;
    ReqType  = 2'b00;
    ReqAddr  = 32'h0000_0000;
    ReqData  = 32'h0000_0077;
    for (int c = 0; c < 3; c++) begin
      chk_beat($sformatf("stall%0d", c), 32'h0000_0104, 4'b1110, 32'h2233_4400);
      chk($sformatf("stall%0d.ready", c), {31'd0, ReqReady}, 32'd0);
      chk($sformatf("stall%0d.done", c), {31'd0, Done}, 32'd0);
      tick();
    end
    MemReady = 1'b1;
    chk_beat("stall.b1_release", 32'h0000_0104, 4'b1110, 32'h2233_4400);
    tick();
    chk_beat("stall.b2", 32'h0000_0108, 4'b0001, 32'h0000_0011);
    tick();
    chk("stall.done", {31'd0, Done}, 32'd1);
    ReqValid = 1'b0;
    tick();
    chk("stall.no_extra_valid", {31'd0, MemValid}, 32'd0);
    chk("stall.no_extra_done", {31'd0, Done}, 32'd0);

    // Reset lands between the two beats of a split store.
    issue(2'b10, 32'h0000_0105, 32'h1122_3344);
    tick();
    chk_beat("rstmid.b2", 32'h0000_0108, 4'b0001, 32'h0000_0011);
    RST_N = 1'b0;
    tick();
    chk("rstmid.valid", {31'd0, MemValid}, 32'd0);
    chk("rstmid.we", {28'd0, MemWE}, 32'd0);
    chk("rstmid.done", {31'd0, Done}, 32'd0);
    chk("rstmid.ready_low", {31'd0, ReqReady}, 32'd0);
    RST_N = 1'b1;
    #1;
    chk("rstmid.ready_high", {31'd0, ReqReady}, 32'd1);
    tick();
    chk("rstmid.still_quiet", {31'd0, MemValid}, 32'd0);

    // Invalid type: no beat, Done next cycle.
    issue(2'b11, 32'h0000_0400, 32'h1234_5678);
    chk("bad.valid", {31'd0, MemValid}, 32'd0);
    chk("bad.we", {28'd0, MemWE}, 32'd0);
    chk("bad.done", {31'd0, Done}, 32'd1);
    chk("bad.ready", {31'd0, ReqReady}, 32'd1);
    tick();
    chk("bad.done_clear", {31'd0, Done}, 32'd0);
    chk("bad.valid_after", {31'd0, MemValid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
